// File: rtl/sap_datapath.sv
// SAP-1 style datapath: shared 8-bit W-bus, PC, MAR, 16x8 RAM, IR, ACC, B, ALU+flags, OUT.
// Latency: bus, ALU and RAM read are combinational; every register load lands on the next clk edge.
// Backpressure: none; strobes are obeyed every cycle unless halted (clr resets, RAM side port writes only under clr).
// Ports: clk/clr (sync active-high reset); control strobes from control_sequencer (low_* are active-low);
//        ALU selects; prog_we/prog_addr/prog_data RAM load port; op_code back to the sequencer;
//        w_bus, out_reg, carry_flag, zero_flag, bus_conflict, halted status outputs.
module sap_datapath (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  input  logic       pc_out_en,
  input  logic       acc_out_en,
  input  logic       subadd_out_en,
  input  logic       low_ld_mar,
  input  logic       low_mem_out_en,
  input  logic       low_ld_ir,
  input  logic       low_ir_out_en,
  input  logic       low_ld_acc,
  input  logic       low_ld_b_reg,
  input  logic       low_ld_out_reg,
  input  logic       low_halt,
  input  logic       sub_add,
  input  logic       xor_ratna,
  input  logic       and_ratna,
  input  logic       or_ratna,
  input  logic       cmp_ratna,
  input  logic       lda_imm,
  input  logic       sta_imm,
  input  logic       add_imm,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [3:0] op_code,
  output logic [7:0] w_bus,
  output logic [7:0] out_reg,
  output logic       carry_flag,
  output logic       zero_flag,
  output logic       bus_conflict,
  output logic       halted
);

  logic [3:0] pc;
  logic [3:0] mar;
  logic [7:0] ir;
  logic [7:0] acc;
  logic [7:0] b_reg;
  logic [7:0] ram [16];

  logic [7:0] ram_rd;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] alu_result;
  logic [7:0] flag_src;
  logic       alu_carry;
  logic       alu_zero;
  logic [2:0] src_cnt;

  assign ram_rd  = ram[mar];
  assign op_code = ir[7:4];

  // Bus source priority: ALU, ACC, RAM, IR operand, PC.
  always_comb begin
    w_bus = 8'h00;
    if (subadd_out_en)        w_bus = alu_result;
    else if (acc_out_en)      w_bus = acc;
    else if (!low_mem_out_en) w_bus = ram_rd;
    else if (!low_ir_out_en)  w_bus = {4'h0, ir[3:0]};
    else if (pc_out_en)       w_bus = {4'h0, pc};
  end

  assign src_cnt = {2'b00, subadd_out_en} + {2'b00, acc_out_en} + {2'b00, ~low_mem_out_en}
                 + {2'b00, ~low_ir_out_en} + {2'b00, pc_out_en};
  assign bus_conflict = (src_cnt >= 3'd2);

  // ALU: 9-bit arithmetic; carry on subtract/compare means "no borrow" (A >= B).
  always_comb begin
    sum9       = {1'b0, acc} + {1'b0, b_reg};
    diff9      = {1'b0, acc} - {1'b0, b_reg};
    alu_result = sum9[7:0];
    alu_carry  = sum9[8];
    if (cmp_ratna) begin
      alu_result = acc;
      alu_carry  = ~diff9[8];
    end else if (sub_add) begin
      alu_result = diff9[7:0];
      alu_carry  = ~diff9[8];
    end else if (xor_ratna) begin
      alu_result = acc ^ b_reg;
      alu_carry  = 1'b0;
    end else if (and_ratna) begin
      alu_result = acc & b_reg;
      alu_carry  = 1'b0;
    end else if (or_ratna) begin
      alu_result = acc | b_reg;
      alu_carry  = 1'b0;
    end else if (lda_imm) begin
      alu_result = b_reg;
      alu_carry  = 1'b0;
    end else if (sta_imm) begin
      alu_result = acc;
      alu_carry  = 1'b0;
    end
    // Compare leaves the result untouched but flags reflect A-B.
    flag_src = cmp_ratna ? diff9[7:0] : alu_result;
    alu_zero = (flag_src == 8'h00);
  end

  // RAM side port is only live while the machine is held in reset; contents survive clr.
  always_ff @(posedge clk) begin
    if (clr && prog_we) ram[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pc         <= 4'h0;
      mar        <= 4'h0;
      ir         <= 8'h00;
      acc        <= 8'h00;
      b_reg      <= 8'h00;
      out_reg    <= 8'h00;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      halted     <= 1'b0;
    end else begin
      if (!low_halt) halted <= 1'b1;
      // Uses the pre-edge halted value, so the halting edge still performs its loads.
      if (!halted) begin
        if (inc)             pc      <= pc + 4'h1;
        if (!low_ld_mar)     mar     <= w_bus[3:0];
        if (!low_ld_ir)      ir      <= w_bus;
        if (!low_ld_acc)     acc     <= w_bus;
        if (!low_ld_b_reg)   b_reg   <= w_bus;
        if (!low_ld_out_reg) out_reg <= w_bus;
        if (subadd_out_en) begin
          carry_flag <= alu_carry;
          zero_flag  <= alu_zero;
        end
      end
    end
  end

endmodule
